// File: rtl/cpu_control_fsm_pkg.sv
// Shared types for the RV32I multicycle control unit: opcodes, funct3 codes,
// datapath mux selects, the control_sig bundle and the FSM state encoding.
package control_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add, f3_sll, f3_slt, f3_sltu, f3_xor, f3_sr, f3_or, f3_and
  } arith_funct3_t;

  typedef enum logic [2:0] {
    f3_lb = 3'b000, f3_lh = 3'b001, f3_lw = 3'b010, f3_lbu = 3'b100, f3_lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    f3_sb = 3'b000, f3_sh = 3'b001, f3_sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops_t;

  typedef enum logic [1:0] {pcm_pc_plus4, pcm_alu_out, pcm_alu_mod2} pcmux_t;
  typedef enum logic {mar_pc_out, mar_alu_out} marmux_t;
  typedef enum logic {cmp_rs2_out, cmp_i_imm} cmpmux_t;
  typedef enum logic {am1_rs1_out, am1_pc_out} alumux1_t;
  typedef enum logic [2:0] {
    am2_i_imm, am2_u_imm, am2_b_imm, am2_s_imm, am2_j_imm, am2_rs2_out
  } alumux2_t;
  typedef enum logic [3:0] {
    rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } regfilemux_t;

  typedef struct packed {
    logic           load_pc;
    logic           load_ir;
    logic           load_regfile;
    logic           load_mar;
    logic           load_mdr;
    logic           load_data_out;
    pcmux_t         pcmux;
    marmux_t        marmux;
    cmpmux_t        cmpmux;
    alumux1_t       alumux1;
    alumux2_t       alumux2;
    regfilemux_t    regfilemux;
    alu_ops_t       aluop;
    branch_funct3_t cmpop;
  } control_sig_t;

  localparam control_sig_t CTRL_DEFAULT = '{
    load_pc: 1'b0, load_ir: 1'b0, load_regfile: 1'b0,
    load_mar: 1'b0, load_mdr: 1'b0, load_data_out: 1'b0,
    pcmux: pcm_pc_plus4, marmux: mar_pc_out, cmpmux: cmp_rs2_out,
    alumux1: am1_rs1_out, alumux2: am2_i_imm, regfilemux: rf_alu_out,
    aluop: alu_add, cmpop: beq
  };

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_ILLEGAL
  } state_t;

  // Store lane mask; sh/sb shift into the addressed byte lanes of the word.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      f3_sb:   return 4'b0001 << lo;
      f3_sh:   return 4'b0011 << lo;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-unit boundary: decoded IR fields and status in, control bundle and
// memory handshake out.
interface cpu_control_fsm_if;
  import control_types::*;

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         br_en;
  logic [1:0]   addr_lo;
  logic         mem_resp;
  control_sig_t ctrl_out;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;

  modport master (
    input  opcode, funct3, funct7, br_en, addr_lo, mem_resp,
    output ctrl_out, mem_read, mem_write, mem_byte_enable
  );

  modport slave (
    output opcode, funct3, funct7, br_en, addr_lo, mem_resp,
    input  ctrl_out, mem_read, mem_write, mem_byte_enable
  );
endinterface

// File: rtl/cpu_control_fsm_decode.sv
// Combinational instruction-field decode: ALU/compare ops, load result
// variant and store byte mask. Holds no state.
module ctrl_decode
  import control_types::*;
(
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic           alt,
  input  logic [1:0]     addr_lo,
  output alu_ops_t       aluop,
  output branch_funct3_t cmpop,
  output logic           is_slt,
  output logic           is_store,
  output regfilemux_t    ld_sel,
  output logic [3:0]     byte_en,
  output logic           bad_funct3
);

  always_comb begin
    aluop      = alu_add;
    cmpop      = beq;
    is_slt     = 1'b0;
    ld_sel     = rf_lw;
    bad_funct3 = 1'b0;
    is_store   = (opcode == op_store);
    byte_en    = store_mask(funct3, addr_lo);
    case (opcode)
      op_imm, op_reg: begin
        case (funct3)
          f3_add:  aluop = (opcode == op_reg && alt) ? alu_sub : alu_add;
          f3_sll:  aluop = alu_sll;
          f3_slt:  begin is_slt = 1'b1; cmpop = blt;  end
          f3_sltu: begin is_slt = 1'b1; cmpop = bltu; end
          f3_xor:  aluop = alu_xor;
          f3_sr:   aluop = alt ? alu_sra : alu_srl;
          f3_or:   aluop = alu_or;
          f3_and:  aluop = alu_and;
          default: aluop = alu_add;
        endcase
      end
      op_br: begin
        cmpop      = branch_funct3_t'(funct3);
        bad_funct3 = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      op_load: begin
        case (funct3)
          f3_lb:   ld_sel = rf_lb;
          f3_lh:   ld_sel = rf_lh;
          f3_lw:   ld_sel = rf_lw;
          f3_lbu:  ld_sel = rf_lbu;
          f3_lhu:  ld_sel = rf_lhu;
          default: bad_funct3 = 1'b1;
        endcase
      end
      op_store: bad_funct3 = (funct3 > 3'b010);
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory and
// drives the datapath control bundle plus the memory handshake.
module cpu_control_fsm
  import control_types::*;
#(
  parameter bit ILLEGAL_FATAL = 1'b1,
  parameter int MEM_WAIT_MAX  = 0
) (
  input logic clk,
  input logic rst,
  cpu_control_fsm_if.master bus
);

  state_t         state, next;
  control_sig_t   ctrl;
  logic           mem_read, mem_write;
  logic [3:0]     mem_byte_enable;

  alu_ops_t       dec_aluop;
  branch_funct3_t dec_cmpop;
  logic           dec_is_slt, dec_is_store, dec_bad_f3;
  regfilemux_t    dec_ld_sel;
  logic [3:0]     dec_byte_en;
  logic           unused;

  assign unused = ^{bus.funct7[6], bus.funct7[4:0]};

  ctrl_decode u_dec (
    .opcode     (bus.opcode),
    .funct3     (bus.funct3),
    .alt        (bus.funct7[5]),
    .addr_lo    (bus.addr_lo),
    .aluop      (dec_aluop),
    .cmpop      (dec_cmpop),
    .is_slt     (dec_is_slt),
    .is_store   (dec_is_store),
    .ld_sel     (dec_ld_sel),
    .byte_en    (dec_byte_en),
    .bad_funct3 (dec_bad_f3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH1;
    else     state <= next;
  end

  // Outputs are gated by rst so an access in flight drops immediately and no
  // load_* strobe can fire while reset is held.
  always_comb begin
    next            = state;
    ctrl            = CTRL_DEFAULT;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'hF;
    if (rst) begin
      next = S_FETCH1;
    end else begin
      case (state)
        S_FETCH1: begin
          ctrl.load_mar = 1'b1;
          ctrl.marmux   = mar_pc_out;
          next          = S_FETCH2;
        end
        S_FETCH2: begin
          mem_read = 1'b1;
          if (bus.mem_resp) begin
            ctrl.load_mdr = 1'b1;
            next          = S_FETCH3;
          end
        end
        S_FETCH3: begin
          ctrl.load_ir = 1'b1;
          next         = S_DECODE;
        end
        S_DECODE: begin
          case (bus.opcode)
            op_imm:            next = S_IMM;
            op_reg:            next = S_REG;
            op_lui:            next = S_LUI;
            op_auipc:          next = S_AUIPC;
            op_br:             next = S_BR;
            op_jal:            next = S_JAL;
            op_jalr:           next = S_JALR;
            op_load, op_store: next = S_CALC_ADDR;
            default:           next = S_ILLEGAL;
          endcase
        end
        S_IMM, S_REG: begin
          ctrl.load_regfile = 1'b1;
          ctrl.load_pc      = 1'b1;
          ctrl.aluop        = dec_aluop;
          ctrl.alumux2      = (state == S_REG) ? am2_rs2_out : am2_i_imm;
          if (dec_is_slt) begin
            ctrl.regfilemux = rf_br_en;
            ctrl.cmpop      = dec_cmpop;
            ctrl.cmpmux     = (state == S_IMM) ? cmp_i_imm : cmp_rs2_out;
          end
          next = S_FETCH1;
        end
        S_LUI: begin
          ctrl.regfilemux   = rf_u_imm;
          ctrl.load_regfile = 1'b1;
          ctrl.load_pc      = 1'b1;
          next              = S_FETCH1;
        end
        S_AUIPC: begin
          ctrl.alumux1      = am1_pc_out;
          ctrl.alumux2      = am2_u_imm;
          ctrl.load_regfile = 1'b1;
          ctrl.load_pc      = 1'b1;
          next              = S_FETCH1;
        end
        S_BR: begin
          ctrl.cmpop   = dec_cmpop;
          ctrl.alumux1 = am1_pc_out;
          ctrl.alumux2 = am2_b_imm;
          ctrl.pcmux   = bus.br_en ? pcm_alu_out : pcm_pc_plus4;
          ctrl.load_pc = 1'b1;
          next         = S_FETCH1;
        end
        // Link value comes from the PC before load_pc takes effect.
        S_JAL, S_JALR: begin
          ctrl.regfilemux   = rf_pc_plus4;
          ctrl.load_regfile = 1'b1;
          ctrl.load_pc      = 1'b1;
          if (state == S_JAL) begin
            ctrl.alumux1 = am1_pc_out;
            ctrl.alumux2 = am2_j_imm;
            ctrl.pcmux   = pcm_alu_out;
          end else begin
            ctrl.alumux1 = am1_rs1_out;
            ctrl.alumux2 = am2_i_imm;
            ctrl.pcmux   = pcm_alu_mod2;
          end
          next = S_FETCH1;
        end
        S_CALC_ADDR: begin
          ctrl.marmux        = mar_alu_out;
          ctrl.load_mar      = 1'b1;
          ctrl.alumux2       = dec_is_store ? am2_s_imm : am2_i_imm;
          ctrl.load_data_out = dec_is_store;
          next               = dec_is_store ? S_ST1 : S_LD1;
        end
        S_LD1: begin
          mem_read = 1'b1;
          if (bus.mem_resp) begin
            ctrl.load_mdr = 1'b1;
            next          = S_LD2;
          end
        end
        S_LD2: begin
          ctrl.regfilemux   = dec_ld_sel;
          ctrl.load_regfile = 1'b1;
          ctrl.load_pc      = 1'b1;
          next              = S_FETCH1;
        end
        S_ST1: begin
          mem_write       = 1'b1;
          mem_byte_enable = dec_byte_en;
          if (bus.mem_resp) next = S_ST2;
        end
        S_ST2: begin
          ctrl.load_pc = 1'b1;
          next         = S_FETCH1;
        end
        S_ILLEGAL: begin
          ctrl.load_pc = 1'b1;
          next         = S_FETCH1;
        end
        default: next = S_FETCH1;
      endcase
    end
  end

  assign bus.ctrl_out        = ctrl;
  assign bus.mem_read        = mem_read;
  assign bus.mem_write       = mem_write;
  assign bus.mem_byte_enable = mem_byte_enable;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ILLEGAL_FATAL && state == S_ILLEGAL)
        $fatal(1, "cpu_control_fsm: illegal opcode %h", bus.opcode);
      if ((state == S_BR || state == S_CALC_ADDR) && dec_bad_f3)
        $fatal(1, "cpu_control_fsm: bad funct3 %h for opcode %h", bus.funct3, bus.opcode);
    end
  end

  generate
    if (MEM_WAIT_MAX > 0) begin : g_wait_watch
      logic [31:0] stall_cnt;
      logic        waiting;
      assign waiting = (state == S_FETCH2 || state == S_LD1 || state == S_ST1) && !bus.mem_resp;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stall_cnt <= '0;
        end else if (waiting) begin
          stall_cnt <= stall_cnt + 32'd1;
          if (stall_cnt + 32'd1 == 32'(MEM_WAIT_MAX))
            $error("cpu_control_fsm: mem_resp stalled %0d cycles", MEM_WAIT_MAX);
        end else begin
          stall_cnt <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: reset, fetch stalls, branches, stores,
// loads, ALU decode and the non-fatal illegal-opcode path.
module tb_cpu_control_fsm;
  import control_types::*;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   c0;

  cpu_control_fsm_if bus();

  cpu_control_fsm #(.ILLEGAL_FATAL(1'b0), .MEM_WAIT_MAX(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // From FETCH1: single-cycle fetch, leaves the FSM in the execute state.
  task automatic to_exec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    set_ir(op, f3, f7);
    bus.mem_resp = 1'b1;
    tick();
    tick();
    bus.mem_resp = 1'b0;
    tick();
    tick();
  endtask

  task automatic back_to_fetch(input string tag);
    tick();
    chk({tag, "_f1_mar"}, bus.ctrl_out.load_mar, 1'b1);
    chk({tag, "_f1_pc"},  bus.ctrl_out.load_pc,  1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_ir(7'h0, 3'h0, 7'h0);
    bus.br_en    = 1'b0;
    bus.addr_lo  = 2'b00;
    bus.mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl",  bus.ctrl_out, CTRL_DEFAULT);
    chk("rst_mrd",   bus.mem_read, 1'b0);
    chk("rst_mwr",   bus.mem_write, 1'b0);
    chk("rst_be",    bus.mem_byte_enable, 4'hF);

    // 1: reset in the middle of a fetch read
    rst = 1'b0; #1;
    chk("t1_f1_mar", bus.ctrl_out.load_mar, 1'b1);
    tick();
    chk("t1_f2_mrd", bus.mem_read, 1'b1);
    chk("t1_f2_mdr", bus.ctrl_out.load_mdr, 1'b0);
    rst = 1'b1; #1;
    chk("t1_rst_mrd",  bus.mem_read, 1'b0);
    chk("t1_rst_ctrl", bus.ctrl_out, CTRL_DEFAULT);
    tick();
    rst = 1'b0; #1;
    chk("t1_rel_mar",    bus.ctrl_out.load_mar, 1'b1);
    chk("t1_rel_marmux", bus.ctrl_out.marmux, mar_pc_out);
    chk("t1_rel_mrd",    bus.mem_read, 1'b0);

    // 2: addi x1,x0,5 with three stalled fetch cycles
    set_ir(7'b0010011, 3'b000, 7'h00);
    tick();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_mrd", bus.mem_read, 1'b1);
      chk("t2_stall_mdr", bus.ctrl_out.load_mdr, 1'b0);
      tick();
    end
    bus.mem_resp = 1'b1; #1;
    chk("t2_resp_mrd", bus.mem_read, 1'b1);
    chk("t2_resp_mdr", bus.ctrl_out.load_mdr, 1'b1);
    tick();
    bus.mem_resp = 1'b0; #1;
    chk("t2_f3_ir",   bus.ctrl_out.load_ir, 1'b1);
    chk("t2_f3_mrd",  bus.mem_read, 1'b0);
    tick();
    chk("t2_dec_ctrl", bus.ctrl_out, CTRL_DEFAULT);
    tick();
    chk("t2_imm_rf",  bus.ctrl_out.load_regfile, 1'b1);
    chk("t2_imm_pc",  bus.ctrl_out.load_pc, 1'b1);
    chk("t2_imm_alu", bus.ctrl_out.aluop, alu_add);
    chk("t2_imm_rfm", bus.ctrl_out.regfilemux, rf_alu_out);
    back_to_fetch("t2");
    chk("t2_cycles", 32'(cyc - c0), 32'd7);

    // 3: taken beq, then not-taken bne
    bus.br_en = 1'b1;
    to_exec(7'b1100011, 3'b000, 7'h00);
    chk("t3_beq_pcmux", bus.ctrl_out.pcmux, pcm_alu_out);
    chk("t3_beq_pc",    bus.ctrl_out.load_pc, 1'b1);
    chk("t3_beq_cmp",   bus.ctrl_out.cmpop, beq);
    chk("t3_beq_am1",   bus.ctrl_out.alumux1, am1_pc_out);
    chk("t3_beq_am2",   bus.ctrl_out.alumux2, am2_b_imm);
    chk("t3_beq_rf",    bus.ctrl_out.load_regfile, 1'b0);
    back_to_fetch("t3a");
    bus.br_en = 1'b0;
    to_exec(7'b1100011, 3'b001, 7'h00);
    chk("t3_bne_pcmux", bus.ctrl_out.pcmux, pcm_pc_plus4);
    chk("t3_bne_cmp",   bus.ctrl_out.cmpop, bne);
    chk("t3_bne_pc",    bus.ctrl_out.load_pc, 1'b1);
    back_to_fetch("t3b");

    // 4: sb to byte lane 2 with two stalls, then sh at offset 0
    bus.addr_lo = 2'b10;
    to_exec(7'b0100011, 3'b000, 7'h00);
    chk("t4_ca_dout",   bus.ctrl_out.load_data_out, 1'b1);
    chk("t4_ca_mar",    bus.ctrl_out.load_mar, 1'b1);
    chk("t4_ca_marmux", bus.ctrl_out.marmux, mar_alu_out);
    chk("t4_ca_am2",    bus.ctrl_out.alumux2, am2_s_imm);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_st1_mwr", bus.mem_write, 1'b1);
      chk("t4_st1_mrd", bus.mem_read, 1'b0);
      chk("t4_st1_be",  bus.mem_byte_enable, 4'b0100);
    end
    tick();
    bus.mem_resp = 1'b1; #1;
    chk("t4_st1_resp_mwr", bus.mem_write, 1'b1);
    chk("t4_st1_resp_be",  bus.mem_byte_enable, 4'b0100);
    tick();
    bus.mem_resp = 1'b0; #1;
    chk("t4_st2_pc",  bus.ctrl_out.load_pc, 1'b1);
    chk("t4_st2_mwr", bus.mem_write, 1'b0);
    back_to_fetch("t4a");
    bus.addr_lo = 2'b00;
    to_exec(7'b0100011, 3'b001, 7'h00);
    tick();
    bus.mem_resp = 1'b1; #1;
    chk("t4_sh_be", bus.mem_byte_enable, 4'b0011);
    tick();
    bus.mem_resp = 1'b0;
    back_to_fetch("t4b");

    // 5: lbu, sub, srai, sltiu decode
    to_exec(7'b0000011, 3'b100, 7'h00);
    chk("t5_ca_am2",  bus.ctrl_out.alumux2, am2_i_imm);
    chk("t5_ca_dout", bus.ctrl_out.load_data_out, 1'b0);
    bus.mem_resp = 1'b1;
    tick();
    chk("t5_ld1_mrd", bus.mem_read, 1'b1);
    chk("t5_ld1_mdr", bus.ctrl_out.load_mdr, 1'b1);
    tick();
    bus.mem_resp = 1'b0; #1;
    chk("t5_ld2_rfm", bus.ctrl_out.regfilemux, rf_lbu);
    chk("t5_ld2_rf",  bus.ctrl_out.load_regfile, 1'b1);
    back_to_fetch("t5a");
    to_exec(7'b0110011, 3'b000, 7'h20);
    chk("t5_sub_alu", bus.ctrl_out.aluop, alu_sub);
    chk("t5_sub_am2", bus.ctrl_out.alumux2, am2_rs2_out);
    back_to_fetch("t5b");
    to_exec(7'b0010011, 3'b101, 7'h20);
    chk("t5_srai_alu", bus.ctrl_out.aluop, alu_sra);
    back_to_fetch("t5c");
    to_exec(7'b0010011, 3'b011, 7'h00);
    chk("t5_sltiu_cmp", bus.ctrl_out.cmpop, bltu);
    chk("t5_sltiu_rfm", bus.ctrl_out.regfilemux, rf_br_en);
    chk("t5_sltiu_cmx", bus.ctrl_out.cmpmux, cmp_i_imm);
    back_to_fetch("t5d");

    // 6: unknown opcode acts as a NOP
    to_exec(7'h7F, 3'b000, 7'h00);
    chk("t6_ill_rf",    bus.ctrl_out.load_regfile, 1'b0);
    chk("t6_ill_pc",    bus.ctrl_out.load_pc, 1'b1);
    chk("t6_ill_pcmux", bus.ctrl_out.pcmux, pcm_pc_plus4);
    back_to_fetch("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
